button_event_gen: RTL and testbench

//  Consumes the debounced pushbutton level from the debounce stage (PB_state) and turns it

---
 rtl/button_event_gen.sv | 105 ++++++++++
 tb/tb_button_event_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into press/release/long/repeat
// single-cycle events and keeps a running press counter.
module button_event_gen #(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8,
    parameter int CNT_W         = 16,
    parameter int PCNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pb_state,
    input  logic              clr_count,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_pulse,
    output logic              repeat_pulse,
    output logic              held,
    output logic [PCNT_W-1:0] press_count
);
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_pb_prev;
    logic [CNT_W-1:0]   r_hold_cnt, w_hold_nxt, r_rep_cnt, w_rep_nxt;
    logic [PCNT_W-1:0]  r_press_count;
    logic               r_press, r_release, r_long, r_repeat, r_held;
    logic               w_press, w_release, w_long, w_repeat;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_rep_nxt   = r_rep_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (pb_state && !r_pb_prev) begin
                    w_press     = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                // release wins over a long event due on the same edge
                if (!pb_state) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_hold_cnt == CNT_W'(LONG_CYCLES - 1)) begin
                    w_long      = 1'b1;
                    w_rep_nxt   = '0;
                    w_state_nxt = LONG;
                end else begin
                    w_hold_nxt  = r_hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (!pb_state) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_rep_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
                    w_repeat    = 1'b1;
                    w_rep_nxt   = '0;
                end else begin
                    w_rep_nxt   = r_rep_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pb_prev     <= 1'b0;
            r_hold_cnt    <= '0;
            r_rep_cnt     <= '0;
            r_press_count <= '0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_long        <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pb_prev     <= pb_state;
            r_hold_cnt    <= w_hold_nxt;
            r_rep_cnt     <= w_rep_nxt;
            r_press_count <= (clr_count ? '0 : r_press_count) + PCNT_W'(w_press);
            r_press       <= w_press;
            r_release     <= w_release;
            r_long        <= w_long;
            r_repeat      <= w_repeat;
            r_held        <= (w_state_nxt != IDLE);
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign held          = r_held;
    assign press_count   = r_press_count;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: scoreboard bench; tasks queue expected events with their cycle,
// the negedge monitor pops and compares every pulse the DUT emits.
`timescale 1ns/1ps
module tb_button_event_gen;
    localparam int LONG = 16;
    localparam int REP  = 8;
    localparam int K_PRESS = 0, K_RELEASE = 1, K_LONG = 2, K_REPEAT = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pb_state = 1'b0;
    logic       clr_count = 1'b0;
    logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] press_count;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt = 8'd0;

    button_event_gen #(
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .CNT_W(16), .PCNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb_state(pb_state), .clr_count(clr_count),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
        .held(held), .press_count(press_count)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [3:0] v;
        ev_t        e;
        v = {repeat_pulse, long_pulse, release_pulse, press_pulse};
        for (int k = 0; k < 4; k++) begin
            if (v[k] === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL event: unexpected kind %0d at cycle %0d, none required", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc !== cyc || e.kind !== k) begin
                        n_err++;
                        $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_press(input int n, input bit clr, input string nm);
        int p;
        pb_state  = 1'b1;
        clr_count = clr;
        p = cyc + 1;
        exp_q.push_back('{p, K_PRESS});
        if (n > LONG) begin
            exp_q.push_back('{p + LONG, K_LONG});
            for (int t = p + LONG + REP; t < p + n; t += REP) exp_q.push_back('{t, K_REPEAT});
        end
        exp_q.push_back('{p + n, K_RELEASE});
        exp_cnt = clr ? 8'd1 : 8'(exp_cnt + 1);
        tick(1);
        clr_count = 1'b0;
        n_cmp++;
        if (held !== 1'b1) begin
            n_err++;
            $display("FAIL %s held_on: got %b, required 1", nm, held);
        end
        tick(n - 1);
        pb_state = 1'b0;
        tick(1);
        n_cmp++;
        if (held !== 1'b0) begin
            n_err++;
            $display("FAIL %s held_off: got %b, required 0", nm, held);
        end
        n_cmp++;
        if (press_count !== exp_cnt) begin
            n_err++;
            $display("FAIL %s press_count: got %0d, required %0d", nm, press_count, exp_cnt);
        end
        tick(1);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL %s missing_events: %0d still pending, required 0", nm, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pb_state = 1'b0;
        tick(3);
        n_cmp++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%0d, required all 0",
                     press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count);
        end
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        tick(2);
    endtask

    task automatic test_short;
        do_press(5, 1'b0, "short");
    endtask

    task automatic test_long;
        do_press(40, 1'b0, "long40");
    endtask

    task automatic test_long_edge;
        do_press(16, 1'b0, "edge16");
        do_press(17, 1'b0, "edge17");
    endtask

    task automatic test_wrap;
        clr_count = 1'b1;
        tick(1);
        clr_count = 1'b0;
        exp_cnt = 8'd0;
        n_cmp++;
        if (press_count !== 8'd0 || held !== 1'b0) begin
            n_err++;
            $display("FAIL clear_alone: got count %0d held %b, required 0 0", press_count, held);
        end
        for (int i = 0; i < 256; i++) begin
            do_press(1, 1'b0, "wrap");
        end
        n_cmp++;
        if (press_count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_count: got %0d, required 0", press_count);
        end
        do_press(1, 1'b0, "after_wrap");
        do_press(2, 1'b1, "clr_with_press");
    endtask

    task automatic test_reset_long;
        int p;
        pb_state = 1'b1;
        p = cyc + 1;
        exp_q.push_back('{p, K_PRESS});
        exp_q.push_back('{p + LONG, K_LONG});
        tick(20);
        #10 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_mid_long: got %b/%b/%b/%b/%b/%0d, required all 0",
                     press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL reset_mid_long events: %0d pending, required 0", exp_q.size());
        end
        exp_q.delete();
        exp_cnt = 8'd0;
        tick(3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_press(3, 1'b0, "press_after_reset");
    endtask

    task automatic test_bounce;
        int p;
        for (int i = 0; i < 4; i++) begin
            pb_state = 1'b1;
            #(10 + 10 * i);
            pb_state = 1'b0;
            tick(1);
        end
        n_cmp++;
        if (held !== 1'b0 || press_count !== exp_cnt) begin
            n_err++;
            $display("FAIL bounce_idle: got held %b count %0d, required 0 %0d", held, press_count, exp_cnt);
        end
        pb_state = 1'b1;
        p = cyc + 1;
        exp_q.push_back('{p, K_PRESS});
        exp_q.push_back('{p + 5, K_RELEASE});
        exp_cnt = 8'(exp_cnt + 1);
        tick(1);
        for (int j = 0; j < 4; j++) begin
            pb_state = 1'b0;
            #(10 + 10 * j);
            pb_state = 1'b1;
            tick(1);
        end
        pb_state = 1'b0;
        tick(2);
        n_cmp++;
        if (press_count !== exp_cnt || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL bounce_press: got count %0d pending %0d, required %0d 0",
                     press_count, exp_q.size(), exp_cnt);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_long_edge();
        test_wrap();
        test_reset_long();
        test_bounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
